// File: rtl/vga_scanout.sv
// Framebuffer scan-out: integer upscale, address generation, palette lookup and
// sync delay matched to the read latency. Palette write port: VGA_SCANOUT_PALETTE_WR_EN.
module vga_scanout #(
    parameter int   WIDTH      = 512,
    parameter int   HEIGHT     = 384,
    parameter int   SCREEN_DIV = 2,
    parameter int   DATA_BITS  = 4,
    parameter int   COLOR_BITS = 6,
    parameter int   READ_DELAY = 2,
    parameter logic SYNC_IDLE  = 1'b1,
    localparam int  ADDR_BITS  = $clog2(WIDTH*HEIGHT)
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic [11:0]             vga_x,
    input  logic [11:0]             vga_y,
    input  logic                    video_active,
    input  logic                    vga_hsync_in,
    input  logic                    vga_vsync_in,
    output logic                    read_en,
    output logic [ADDR_BITS-1:0]    read_addr,
    input  logic [DATA_BITS-1:0]    read_data,
    output logic [COLOR_BITS-1:0]   vga_r,
    output logic [COLOR_BITS-1:0]   vga_g,
    output logic [COLOR_BITS-1:0]   vga_b,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
`ifdef VGA_SCANOUT_PALETTE_WR_EN
    input  logic                    pal_we,
    input  logic [DATA_BITS-1:0]    pal_addr,
    input  logic [3*COLOR_BITS-1:0] pal_data,
`endif
    output logic                    frame_start
);

    localparam int LAT   = READ_DELAY + 2;
    localparam int SHIFT = $clog2(SCREEN_DIV);
    localparam int IMG_W = WIDTH * SCREEN_DIV;
    localparam int IMG_H = HEIGHT * SCREEN_DIV;
    localparam int PW    = 3 * COLOR_BITS;

    // Grey level for palette index idx: index bits repeated MSB-first, then truncated.
    function automatic logic [COLOR_BITS-1:0] grey_level(input int idx);
        logic [DATA_BITS-1:0]  ib;
        logic [COLOR_BITS-1:0] c;
        ib = DATA_BITS'(idx);
        c  = '0;
        for (int k = 0; k < COLOR_BITS; k++)
            c[COLOR_BITS-1-k] = ib[DATA_BITS-1-(k % DATA_BITS)];
        return c;
    endfunction

    logic                 in_y;
    logic                 in_region;
    logic                 new_line;
    logic                 fetch;
    logic [11:0]          y_prev_q;
    logic [ADDR_BITS-1:0] row_base_q, row_base_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic                 read_en_q;
    logic [ADDR_BITS-1:0] read_addr_q;

    always_comb begin
        in_y       = 32'(vga_y) < IMG_H;
        in_region  = (32'(vga_x) < IMG_W) && in_y;
        fetch      = video_active && in_region;
        new_line   = vga_y != y_prev_q;
        row_base_d = row_base_q;
        // Bump only inside the image so the base never runs past the address space.
        if (vga_y == 12'd0)
            row_base_d = '0;
        else if (new_line && in_y && ((32'(vga_y) & (SCREEN_DIV - 1)) == 0))
            row_base_d = row_base_q + ADDR_BITS'(WIDTH);
        addr_d = row_base_d + ADDR_BITS'(vga_x >> SHIFT);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            y_prev_q    <= '0;
            row_base_q  <= '0;
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
        end else begin
            y_prev_q   <= vga_y;
            row_base_q <= row_base_d;
            read_en_q  <= fetch;
            if (fetch)
                read_addr_q <= addr_d;
        end
    end

    assign read_en   = read_en_q;
    assign read_addr = read_addr_q;

    // Active/region stop one stage short: the RGB register is the last stage.
    logic [LAT-2:0] act_q, reg_q;
    logic [LAT-1:0] hs_q, vs_q, fs_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            act_q <= '0;
            reg_q <= '0;
            hs_q  <= {LAT{SYNC_IDLE}};
            vs_q  <= {LAT{SYNC_IDLE}};
            fs_q  <= '0;
        end else begin
            act_q <= {act_q[LAT-3:0], video_active};
            reg_q <= {reg_q[LAT-3:0], in_region};
            hs_q  <= {hs_q[LAT-2:0], vga_hsync_in};
            vs_q  <= {vs_q[LAT-2:0], vga_vsync_in};
            fs_q  <= {fs_q[LAT-2:0], video_active && (vga_x == 12'd0) && (vga_y == 12'd0)};
        end
    end

    logic [PW-1:0] pal_rd;

`ifdef VGA_SCANOUT_PALETTE_WR_EN
    localparam int NPAL = 1 << DATA_BITS;
    logic [PW-1:0] pal_q [NPAL];

    // Lookup and write share an edge, so a same-cycle lookup sees the old entry.
    assign pal_rd = pal_q[read_data];

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++)
                pal_q[i] <= {3{grey_level(i)}};
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end
`else
    always_comb begin
        pal_rd = {3{grey_level(int'(read_data))}};
    end
`endif

    logic [PW-1:0] rgb_q;

    always_ff @(posedge clk_pixel) begin
        if (reset)
            rgb_q <= '0;
        else if (act_q[LAT-2] && reg_q[LAT-2])
            rgb_q <= pal_rd;
        else
            rgb_q <= '0;
    end

    assign vga_r       = rgb_q[PW-1 -: COLOR_BITS];
    assign vga_g       = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign vga_b       = rgb_q[COLOR_BITS-1:0];
    assign vga_hsync   = hs_q[LAT-1];
    assign vga_vsync   = vs_q[LAT-1];
    assign frame_start = fs_q[LAT-1];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: sparse raster scan with random pixels, framebuffer contents and
// activity, checked every cycle against a coordinate-level model of the scan-out.
`timescale 1ns/1ps
module tb_vga_scanout;
    localparam int   WIDTH = 512, HEIGHT = 384, DIV = 2, DB = 4, CB = 6, RD = 2;
    localparam int   LAT = RD + 2;
    localparam int   AB = $clog2(WIDTH*HEIGHT);
    localparam int   IMG_W = WIDTH*DIV, IMG_H = HEIGHT*DIV;
    localparam int   ACT_W = 1100, ACT_H = 800, TOT_W = 1280, TOT_H = 820;
    localparam logic SYNC_IDLE = 1'b1;

    logic          clk_pixel = 1'b0;
    logic          reset = 1'b1;
    logic [11:0]   vga_x = '0, vga_y = '0;
    logic          video_active = 1'b0, vga_hsync_in = 1'b1, vga_vsync_in = 1'b1;
    logic          read_en;
    logic [AB-1:0] read_addr;
    logic [DB-1:0] read_data = '0;
    logic [CB-1:0] vga_r, vga_g, vga_b;
    logic          vga_hsync, vga_vsync, frame_start;
`ifdef VGA_SCANOUT_PALETTE_WR_EN
    logic            pal_we = 1'b0;
    logic [DB-1:0]   pal_addr = '0;
    logic [3*CB-1:0] pal_data = '0;
`endif

    always #5 clk_pixel = ~clk_pixel;

    vga_scanout dut (
        .clk_pixel(clk_pixel), .reset(reset),
        .vga_x(vga_x), .vga_y(vga_y), .video_active(video_active),
        .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
`ifdef VGA_SCANOUT_PALETTE_WR_EN
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
`endif
        .frame_start(frame_start)
    );

    typedef struct { bit rst; bit act; int x; int y; bit hs; bit vs; } in_t;

    in_t           hist[$];
    int            ncyc = 0;
    int            n_cmp = 0, n_err = 0;
    logic [DB-1:0] fb [0:WIDTH*HEIGHT-1];
    logic [17:0]   pal_m [16];
    bit            mem_en[$];
    logic [AB-1:0] mem_ad[$];
    logic [AB-1:0] exp_addr = '0;
    bit            pend_we = 0, pend_rst = 0;
    logic [DB-1:0] pend_a = '0;
    logic [17:0]   pend_d = '0;

    function automatic logic [CB-1:0] grey(input int i);
        int v = i, bits = DB;
        while (bits < CB) begin v = (v << DB) | i; bits += DB; end
        return CB'(v >> (bits - CB));
    endfunction

    function automatic void reload_grey();
        for (int i = 0; i < 16; i++) pal_m[i] = {3{grey(i)}};
    endfunction

    function automatic bit in_img(input int x, input int y);
        return x < IMG_W && y < IMG_H;
    endfunction

    function automatic int img_addr(input int x, input int y);
        return (y / DIV) * WIDTH + x / DIV;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, ncyc, got, want);
        end
    endtask

    task automatic step(input bit rst_v, input bit act_v, input int x, input int y);
        in_t           e1, eL, nw;
        bit            valid;
        bit            exp_en;
        logic [17:0]   exp_rgb;
        int            ei;
        @(negedge clk_pixel);
        // framebuffer: answer the request seen RD cycles ago
        mem_en.push_front(read_en);
        mem_ad.push_front(read_addr);
        if (mem_en.size() > RD) begin
            read_data = (mem_en[RD] === 1'b1) ? fb[mem_ad[RD]] : DB'($urandom);
            void'(mem_en.pop_back());
            void'(mem_ad.pop_back());
        end
        if (ncyc > 0) begin
            e1 = hist[ncyc-1];
            exp_en = 0;
            if (e1.rst) exp_addr = '0;
            else begin
                exp_en = e1.act && in_img(e1.x, e1.y);
                if (exp_en) exp_addr = AB'(img_addr(e1.x, e1.y));
            end
            ei = ncyc - LAT;
            valid = ei >= 0;
            for (int k = (ei < 0 ? 0 : ei); k < ncyc; k++) if (hist[k].rst) valid = 0;
            if (valid) eL = hist[ei];
            exp_rgb = '0;
            if (valid && eL.act && in_img(eL.x, eL.y)) exp_rgb = pal_m[fb[img_addr(eL.x, eL.y)]];
            chk("read_en", 32'(read_en), 32'(exp_en));
            chk("read_addr", 32'(read_addr), 32'(exp_addr));
            chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
            chk("hsync", 32'(vga_hsync), 32'(valid ? eL.hs : SYNC_IDLE));
            chk("vsync", 32'(vga_vsync), 32'(valid ? eL.vs : SYNC_IDLE));
            chk("frame_start", 32'(frame_start), 32'(valid && eL.act && eL.x == 0 && eL.y == 0));
            // hand-computed anchors
            if (e1.rst) begin
                chk("lit_rst_en", 32'(read_en), 32'd0);
                chk("lit_rst_addr", 32'(read_addr), 32'd0);
                chk("lit_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
                chk("lit_rst_hs", 32'(vga_hsync), 32'd1);
                chk("lit_rst_vs", 32'(vga_vsync), 32'd1);
                chk("lit_rst_fs", 32'(frame_start), 32'd0);
            end else if (e1.act) begin
                if (e1.x == 0 && e1.y == 0) begin
                    chk("lit_00_en", 32'(read_en), 32'd1);
                    chk("lit_00_addr", 32'(read_addr), 32'd0);
                end
                if (e1.x == 7 && e1.y == 5) chk("lit_7_5_addr", 32'(read_addr), 32'd1027);
                if (e1.x == 1023 && e1.y == 0) chk("lit_1023_0_addr", 32'(read_addr), 32'd511);
                if (e1.x == 1023 && e1.y == 767) chk("lit_1023_767_addr", 32'(read_addr), 32'd196607);
                if (e1.x == 1024) chk("lit_border_en", 32'(read_en), 32'd0);
            end
            if (valid && eL.act && eL.x == 0 && eL.y == 0) begin
                chk("lit_00_fs", 32'(frame_start), 32'd1);
`ifndef VGA_SCANOUT_PALETTE_WR_EN
                chk("lit_00_rgb", 32'({vga_r, vga_g, vga_b}), 32'h3FFFF);
`endif
            end
`ifndef VGA_SCANOUT_PALETTE_WR_EN
            if (valid && eL.act && eL.x == 7 && eL.y == 5)
                chk("lit_7_5_rgb", 32'({vga_r, vga_g, vga_b}), 32'h15555);
`endif
        end
        // palette state seen by later lookups: previous cycle's write, then reset reload
        if (pend_we) pal_m[pend_a] = pend_d;
        if (pend_rst) reload_grey();
        pend_rst = rst_v;
        pend_we  = 0;
`ifdef VGA_SCANOUT_PALETTE_WR_EN
        pal_we   = ($urandom_range(0, 5) == 0);
        pal_addr = DB'($urandom);
        pal_data = 18'($urandom);
        pend_we  = pal_we;
        pend_a   = pal_addr;
        pend_d   = pal_data;
`endif
        nw.rst = rst_v; nw.act = act_v; nw.x = x; nw.y = y;
        nw.hs  = !(x >= 1120 && x < 1160);
        nw.vs  = !(y >= 805 && y < 808);
        reset        = rst_v;
        vga_x        = 12'(x);
        vga_y        = 12'(y);
        video_active = act_v;
        vga_hsync_in = nw.hs;
        vga_vsync_in = nw.vs;
        hist.push_back(nw);
        ncyc++;
    endtask

    function automatic bit act_of(input int x, input int y);
        return x < ACT_W && y < ACT_H && ($urandom_range(0, 15) != 0);
    endfunction

    // Sparse raster: a handful of x positions per line, every line visited in order.
    task automatic frame(input int stop_y);
        int xs[8];
        for (int y = 0; y < TOT_H; y++) begin
            xs[0] = 0; xs[1] = 7; xs[2] = 1023; xs[3] = 1024; xs[4] = 1130;
            xs[5] = $urandom_range(0, TOT_W-1);
            xs[6] = $urandom_range(0, TOT_W-1);
            xs[7] = $urandom_range(0, IMG_W-1);
            for (int i = 0; i < 8; i++) begin
                step(0, act_of(xs[i], y), xs[i], y);
                if (y == stop_y && i == 4) begin
                    step(1, 1'b1, 1131, y);
                    for (int k = 0; k < LAT + 3; k++) step(0, 1'b0, 1200 + k, y);
                    return;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WIDTH*HEIGHT; i++) fb[i] = DB'($urandom);
        fb[0]    = 4'hF;
        fb[1027] = 4'h5;
        reload_grey();
        repeat (3) step(1, 1'b0, 0, 0);
        frame(-1);
        frame(10);
        frame(-1);
        repeat (LAT + 2) step(0, 1'b0, 1200, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter WIDTH, default 512: source image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 384: source image height in pixels.
REQ-003 SHALL have parameter SCREEN_DIV, default 2: integer upscale factor, legal values 1, 2 and 4.
REQ-004 SHALL have parameter DATA_BITS, default 4: palette index width.
REQ-005 SHALL have parameter COLOR_BITS, default 6: width of each colour channel.
REQ-006 SHALL have parameter READ_DELAY, default 2: framebuffer read latency in cycles, legal range 1..4.
REQ-007 SHALL have parameter SYNC_IDLE, default 1: inactive level of the sync outputs.
REQ-008 SHALL have the following ports (clock and reset first). One clock (clk_pixel); reset is synchronous and active-high.
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- vga_x  in  12  timing-controller x coordinate.
- vga_y  in  12  timing-controller y coordinate.
- video_active  in  1  visible region.
- vga_hsync_in  in  1  raw hsync.
- vga_vsync_in  in  1  raw vsync.
- read_en  out  1  framebuffer read strobe.
- read_addr  out  ADDR_BITS = clog2(WIDTH*HEIGHT)  framebuffer address.
- read_data  in  DATA_BITS  palette index, valid READ_DELAY cycles after read_en.
- vga_r, vga_g, vga_b  out  COLOR_BITS each  pixel colour.
- vga_hsync, vga_vsync  out  1  delayed syncs.
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).
- pal_we  in  1  palette write enable (only when the macro in REQ-023 is defined).
- pal_addr  in  DATA_BITS  palette write index (only when the macro in REQ-023 is defined).
- pal_data  in  3*COLOR_BITS  palette write data as {R,G,B} (only when the macro in REQ-023 is defined).

Function
REQ-009 SHALL define the image region as vga_x < WIDTH*SCREEN_DIV and vga_y < HEIGHT*SCREEN_DIV.
REQ-010 Stage 0 SHALL register read_en = video_active AND inside the image region, and read_addr = (vga_y/SCREEN_DIV)*WIDTH + vga_x/SCREEN_DIV.
REQ-011 SHALL generate the row base (vga_y/SCREEN_DIV)*WIDTH incrementally with no multiplier.
- Reset to 0 when vga_y == 0.
- Incremented by WIDTH on the first cycle of each line where vga_y is a nonzero multiple of SCREEN_DIV.
- Held on all other lines.
REQ-012 SHALL hold read_addr at its last value when read_en is 0.
REQ-013 SHALL delay video_active, the image-region flag, vga_hsync_in and vga_vsync_in through a shift pipeline of LAT = READ_DELAY+2 stages.
REQ-014 SHALL register the palette lookup of read_data in the final stage, so total pixel latency from coordinate input to RGB output is LAT cycles.
REQ-015 SHALL output palette[read_data] when the delayed video_active and delayed in-region flags are both 1.
REQ-016 SHALL output RGB all zeros when delayed video_active = 1 and delayed in-region = 0 (letterbox border).
REQ-017 SHALL output RGB all zeros when delayed video_active = 0.
REQ-018 SHALL pulse frame_start for exactly one cycle, LAT cycles after an input cycle with vga_x == 0, vga_y == 0 and video_active = 1.
REQ-019 SHALL produce no read_en for coordinates at or beyond the image bounds, including the wrap from the last line to line 0.

Reset
REQ-020 While reset = 1 at a clock edge, outputs SHALL become:
- read_en = 0, read_addr = 0, row base = 0.
- RGB = 0, frame_start = 0.
- vga_hsync = vga_vsync = SYNC_IDLE.
- All pipeline stages cleared to inactive.
REQ-021 SHALL load palette entry i at reset with a grey ramp: each channel = i replicated/truncated to COLOR_BITS (i=5, 4-bit index, 6-bit channel -> 010101).
REQ-022 A reset asserted mid-line SHALL discard in-flight pixels; the first valid output follows LAT cycles after the first active in-region coordinate after reset deasserts.

Configuration
REQ-023 With macro VGA_SCANOUT_PALETTE_WR_EN defined, the palette write port SHALL behave as follows.
- pal_we = 1 writes pal_data into palette[pal_addr] at the clock edge.
- A lookup of the same entry in the same cycle returns the old value.
- Reset reloads the grey ramp of REQ-021.
REQ-024 Without VGA_SCANOUT_PALETTE_WR_EN, the pal_* ports SHALL be absent and the palette SHALL be the constant grey ramp.

Verification
REQ-025 Reset, then scan (0,0) with SCREEN_DIV=2 and READ_DELAY=2 -> read_en=1 and read_addr=0 one cycle later; RGB appears 4 cycles later.
REQ-026 Input (vga_x=7, vga_y=5) -> read_addr = 2*512+3 = 1027.
REQ-027 Input vga_x=1023 (in region, last column) -> read_addr = 511 on line 0; at vga_y=767 -> read_addr = 383*512+511 = 196607, with no address overflow.
REQ-028 WIDTH=320, HEIGHT=240, SCREEN_DIV=2 on a 1024x768 raster -> vga_x=700 gives read_en=0 and RGB=0 while video_active=1; syncs are delayed exactly 4 cycles.
REQ-029 With VGA_SCANOUT_PALETTE_WR_EN: write palette[3]=18'h3FFFF while read_data=3 -> old colour on that pixel, 18'h3FFFF on the next one.
REQ-030 Assert reset for 1 cycle mid-line -> the next cycle shows RGB=0 and syncs=SYNC_IDLE, and frame_start does not pulse until the next (0,0).
